// File: rtl/aes128_type_pkg.sv
// Shared AES-128 types for the round-key store: FSM state encoding, key and index types.
// The SCRUB state is only entered when AES128_RKS_SCRUB_EN is defined.
package aes128_type_pkg;

    localparam int unsigned AES128_NUM_RKEYS = 11;

    typedef logic [3:0]   rkey_idx_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitHi,
        StStore,
        StReq,
        StWaitLo,
        StReady,
        StScrub
    } rks_state_t;

endpackage

// File: rtl/aes128_rks_regfile.sv
// Round-key register file: one synchronous write port, one registered read port that
// holds its last value when no read is issued.
import aes128_type_pkg::*;

module aes128_rks_regfile #(
    parameter int unsigned Depth = AES128_NUM_RKEYS,
    parameter int unsigned Width = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  rkey_idx_t        waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  rkey_idx_t        raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/aes128_round_key_store.sv
// Captures the 11 AES-128 round keys from the expansion stage and serves them by index.
// Optional zeroise (clear_i, SCRUB state) is built when AES128_RKS_SCRUB_EN is defined.
import aes128_type_pkg::*;

module aes128_round_key_store #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_W      = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             load_i,
    output logic             ready_o,
    output logic             busy_o,
    input  logic             rd_en_i,
    input  logic [3:0]       rd_round_i,
    output logic [KEY_W-1:0] rd_key_o,
    output logic             rd_valid_o,
    output logic [KEY_W-1:0] exp_key_o,
    output logic             exp_start_o,
    output logic             exp_key_req_o,
    input  logic [KEY_W-1:0] exp_key_i,
    input  logic             exp_valid_i
`ifdef AES128_RKS_SCRUB_EN
    ,
    input  logic             clear_i
`endif
);

    localparam rkey_idx_t LastIdx = 4'(NUM_ROUNDS);

    rks_state_t       state_q;
    rkey_idx_t        rnd_cnt_q;
    logic [KEY_W-1:0] exp_key_q;
    logic             start_q;
    logic             req_q;
    logic             ready_q;
    logic             busy_q;
    logic             rd_valid_q;

    logic             clear_req;
    logic             rd_accept;
    logic             wr_en;
    logic [KEY_W-1:0] wr_data;

`ifdef AES128_RKS_SCRUB_EN
    assign clear_req = clear_i;
`else
    assign clear_req = 1'b0;
`endif

    // A load arriving with a read in READY wins; the read is dropped.
    assign rd_accept = rd_en_i && ready_q && (rd_round_i <= LastIdx) && !load_i && !clear_req;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            rnd_cnt_q <= '0;
            exp_key_q <= '0;
            start_q   <= 1'b0;
            req_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            req_q   <= 1'b0;
            if (clear_req) begin
                state_q   <= StScrub;
                rnd_cnt_q <= '0;
                exp_key_q <= '0;
                ready_q   <= 1'b0;
                busy_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle, StReady: begin
                        if (load_i) begin
                            exp_key_q <= key_i;
                            rnd_cnt_q <= '0;
                            ready_q   <= 1'b0;
                            busy_q    <= 1'b1;
                            start_q   <= 1'b1;
                            state_q   <= StStart;
                        end
                    end
                    StStart: state_q <= StWaitHi;
                    StWaitHi: begin
                        if (exp_valid_i) begin
                            state_q <= StStore;
                        end
                    end
                    StStore: begin
                        if (rnd_cnt_q == LastIdx) begin
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StReady;
                        end else begin
                            rnd_cnt_q <= rnd_cnt_q + 4'd1;
                            req_q     <= 1'b1;
                            state_q   <= StReq;
                        end
                    end
                    StReq: state_q <= StWaitLo;
                    // Expansion valid lingers one cycle after a request; skip that stale key.
                    StWaitLo: begin
                        if (!exp_valid_i) begin
                            state_q <= StWaitHi;
                        end
                    end
`ifdef AES128_RKS_SCRUB_EN
                    StScrub: begin
                        if (rnd_cnt_q == LastIdx) begin
                            rnd_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            rnd_cnt_q <= rnd_cnt_q + 4'd1;
                        end
                    end
`endif
                    default: begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = exp_key_i;
        if (state_q == StStore) begin
            wr_en = 1'b1;
        end
`ifdef AES128_RKS_SCRUB_EN
        if (state_q == StScrub) begin
            wr_en   = 1'b1;
            wr_data = '0;
        end
`endif
    end

    aes128_rks_regfile #(
        .Depth(NUM_ROUNDS + 1),
        .Width(KEY_W)
    ) u_regfile (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (wr_en),
        .waddr_i(rnd_cnt_q),
        .wdata_i(wr_data),
        .re_i   (rd_accept),
        .raddr_i(rd_round_i),
        .rdata_o(rd_key_o)
    );

    assign ready_o       = ready_q;
    assign busy_o        = busy_q;
    assign rd_valid_o    = rd_valid_q;
    assign exp_key_o     = exp_key_q;
    assign exp_start_o   = start_q;
    assign exp_key_req_o = req_q;

endmodule

// File: tb/tb_aes128_round_key_store.sv
// Directed bench for aes128_round_key_store using the FIPS-197 A.1 key schedule; the
// expansion stage is a table-driven model that presents keys byte-reversed.
module tb_aes128_round_key_store;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [127:0] key_i = '0;
    logic         load_i = 1'b0;
    logic         ready_o, busy_o;
    logic         rd_en_i = 1'b0;
    logic [3:0]   rd_round_i = '0;
    logic [127:0] rd_key_o;
    logic         rd_valid_o;
    logic [127:0] exp_key_o;
    logic         exp_start_o, exp_key_req_o;
    logic [127:0] m_key;
    logic         m_valid;
`ifdef AES128_RKS_SCRUB_EN
    logic         clear_i = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    int start_cnt = 0;
    logic [127:0] last_key = '0;

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] AltKey  = 128'hffeeddccbbaa99887766554433221100;

    aes128_round_key_store dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .key_i        (key_i),
        .load_i       (load_i),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .rd_en_i      (rd_en_i),
        .rd_round_i   (rd_round_i),
        .rd_key_o     (rd_key_o),
        .rd_valid_o   (rd_valid_o),
        .exp_key_o    (exp_key_o),
        .exp_start_o  (exp_start_o),
        .exp_key_req_o(exp_key_req_o),
        .exp_key_i    (m_key),
        .exp_valid_i  (m_valid)
`ifdef AES128_RKS_SCRUB_EN
        ,
        .clear_i      (clear_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] fips_rk(input int r);
        case (r)
            0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:  return 128'ha0fafe1788542cb123a339392a6c7605;
            2:  return 128'hf2c295f27a96b9435935807a7359f67f;
            3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  return 128'head27321b58dbad2312bf5607f8d292f;
            9:  return 128'hac7766f319fadc2128d12941575c006e;
            10: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            default: return '0;
        endcase
    endfunction

    function automatic logic [127:0] brev(input logic [127:0] v);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) o[b*8 +: 8] = v[(15-b)*8 +: 8];
        return o;
    endfunction

    // Expansion-stage model: valid stays high one cycle after a request, then drops.
    typedef enum int {MIdle, MStale, MDelay} mph_t;
    mph_t m_ph;
    int   m_idx, m_tmr;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_valid <= 1'b0; m_key <= '0; m_idx <= 0; m_tmr <= 0; m_ph <= MIdle;
        end else if (exp_start_o) begin
            m_idx <= 0; m_tmr <= 2; m_valid <= 1'b0; m_ph <= MDelay;
        end else if (exp_key_req_o) begin
            m_ph <= MStale;
        end else begin
            case (m_ph)
                MStale: begin
                    m_valid <= 1'b0; m_idx <= m_idx + 1; m_tmr <= 2; m_ph <= MDelay;
                end
                MDelay: begin
                    if (m_tmr == 0) begin
                        m_valid <= 1'b1; m_key <= brev(fips_rk(m_idx)); m_ph <= MIdle;
                    end else begin
                        m_tmr <= m_tmr - 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk_i) begin
        if (exp_key_req_o) req_cnt <= req_cnt + 1;
        if (exp_start_o) start_cnt <= start_cnt + 1;
    end

    task automatic pulse_load(input logic [127:0] k);
        key_i = k; load_i = 1'b1;
        @(negedge clk_i);
        load_i = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] idx);
        rd_en_i = 1'b1; rd_round_i = idx;
        @(negedge clk_i);
        rd_en_i = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ready_o) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset;
        bit all_zero;
        @(negedge clk_i); @(negedge clk_i);
        all_zero = !ready_o && !busy_o && !rd_valid_o && (rd_key_o == '0) && (exp_key_o == '0)
                   && !exp_start_o && !exp_key_req_o;
        checks++;
        if (all_zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b busy=%b rv=%b key=%h ek=%h st=%b rq=%b, want all 0",
                     ready_o, busy_o, rd_valid_o, rd_key_o, exp_key_o, exp_start_o, exp_key_req_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_load_read;
        bit ok;
        int rbase = req_cnt;
        pulse_load(FipsKey);
        checks++;
        if (exp_start_o !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b want 1", exp_start_o); end
        checks++;
        if (exp_key_o !== FipsKey) begin errors++; $display("FAIL exp_key: got %h want %h", exp_key_o, FipsKey); end
        checks++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
            errors++; $display("FAIL busy_during_build: busy=%b ready=%b want 1/0", busy_o, ready_o);
        end
        @(negedge clk_i);
        checks++;
        if (exp_start_o !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %b want 0", exp_start_o); end
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ready_timeout: ready=%b want 1", ready_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_after_ready: got %b want 0", busy_o); end
        checks++;
        if (req_cnt - rbase != 10) begin errors++; $display("FAIL req_count: got %0d want 10", req_cnt - rbase); end
        do_read(4'd1);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== brev(fips_rk(1))) begin
            errors++; $display("FAIL read_round1: valid=%b key=%h want 1 %h", rd_valid_o, rd_key_o, brev(fips_rk(1)));
        end
        last_key = brev(fips_rk(1));
        checks++;
        if (rd_valid_o !== 1'b0 || rd_key_o !== last_key) begin
            @(negedge clk_i);
        end
        @(negedge clk_i);
        if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b want 0", rd_valid_o); end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        rd_en_i = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            rd_round_i = 4'(r);
            @(negedge clk_i);
            if (rd_valid_o === 1'b1) pulses++;
            checks++;
            if (rd_key_o !== brev(fips_rk(r))) begin
                errors++; $display("FAIL b2b_round%0d: got %h want %h", r, rd_key_o, brev(fips_rk(r)));
            end
        end
        rd_en_i = 1'b0;
        last_key = brev(fips_rk(0));
        checks++;
        if (pulses != 11) begin errors++; $display("FAIL b2b_valid_count: got %0d want 11", pulses); end
        @(negedge clk_i);
        checks++;
        if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_end: got %b want 0", rd_valid_o); end
    endtask

    task automatic test_load_ignored;
        bit ok;
        int rbase = req_cnt;
        int sbase = start_cnt;
        pulse_load(FipsKey);
        for (int i = 0; i < 200 && (req_cnt - rbase) < 4; i++) @(negedge clk_i);
        checks++;
        if (req_cnt - rbase < 4) begin errors++; $display("FAIL midbuild_timeout: reqs=%0d want >=4", req_cnt - rbase); end
        pulse_load(AltKey);
        checks++;
        if (exp_key_o !== FipsKey) begin errors++; $display("FAIL ignored_load_key: got %h want %h", exp_key_o, FipsKey); end
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL ignored_load_busy: got %b want 1", busy_o); end
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ignored_ready_timeout: ready=%b want 1", ready_o); end
        checks++;
        if (req_cnt - rbase != 10 || start_cnt - sbase != 1) begin
            errors++; $display("FAIL ignored_pulses: req=%0d start=%0d want 10 1", req_cnt - rbase, start_cnt - sbase);
        end
        for (int r = 0; r <= 10; r++) begin
            do_read(4'(r));
            checks++;
            if (rd_valid_o !== 1'b1 || rd_key_o !== brev(fips_rk(r))) begin
                errors++; $display("FAIL ignored_store%0d: valid=%b got %h want %h", r, rd_valid_o, rd_key_o, brev(fips_rk(r)));
            end
        end
        last_key = brev(fips_rk(10));
    endtask

    task automatic test_bad_reads;
        bit ok;
        pulse_load(FipsKey);
        do_read(4'd3);
        checks++;
        if (rd_valid_o !== 1'b0 || rd_key_o !== last_key) begin
            errors++; $display("FAIL read_not_ready: valid=%b key=%h want 0 %h", rd_valid_o, rd_key_o, last_key);
        end
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bad_ready_timeout: ready=%b want 1", ready_o); end
        do_read(4'd11);
        checks++;
        if (rd_valid_o !== 1'b0 || rd_key_o !== last_key) begin
            errors++; $display("FAIL read_idx11: valid=%b key=%h want 0 %h", rd_valid_o, rd_key_o, last_key);
        end
        do_read(4'd15);
        checks++;
        if (rd_valid_o !== 1'b0 || rd_key_o !== last_key) begin
            errors++; $display("FAIL read_idx15: valid=%b key=%h want 0 %h", rd_valid_o, rd_key_o, last_key);
        end
        key_i = FipsKey; load_i = 1'b1; rd_en_i = 1'b1; rd_round_i = 4'd2;
        @(negedge clk_i);
        load_i = 1'b0; rd_en_i = 1'b0;
        checks++;
        if (rd_valid_o !== 1'b0 || busy_o !== 1'b1 || ready_o !== 1'b0) begin
            errors++; $display("FAIL load_read_collision: valid=%b busy=%b ready=%b want 0 1 0", rd_valid_o, busy_o, ready_o);
        end
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL collision_ready_timeout: ready=%b want 1", ready_o); end
    endtask

    task automatic test_reset_mid_build;
        bit ok;
        bit all_zero;
        int rbase = req_cnt;
        pulse_load(FipsKey);
        for (int i = 0; i < 300 && (req_cnt - rbase) < 6; i++) @(negedge clk_i);
        checks++;
        if (req_cnt - rbase < 6) begin errors++; $display("FAIL rst_mid_timeout: reqs=%0d want >=6", req_cnt - rbase); end
        rst_i = 1'b1;
        #1;
        all_zero = !ready_o && !busy_o && !rd_valid_o && (rd_key_o == '0) && (exp_key_o == '0)
                   && !exp_start_o && !exp_key_req_o;
        checks++;
        if (all_zero !== 1'b1) begin
            errors++; $display("FAIL async_reset: busy=%b key=%h ek=%h want all 0", busy_o, rd_key_o, exp_key_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        last_key = '0;
        @(negedge clk_i);
        pulse_load(FipsKey);
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rebuild_ready_timeout: ready=%b want 1", ready_o); end
        for (int r = 0; r <= 10; r += 5) begin
            do_read(4'(r));
            checks++;
            if (rd_valid_o !== 1'b1 || rd_key_o !== brev(fips_rk(r))) begin
                errors++; $display("FAIL rebuild_round%0d: valid=%b got %h want %h", r, rd_valid_o, rd_key_o, brev(fips_rk(r)));
            end
            last_key = brev(fips_rk(r));
        end
    endtask

`ifdef AES128_RKS_SCRUB_EN
    task automatic test_scrub;
        bit ok;
        int nz = 0;
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b1 || exp_key_o !== '0) begin
            errors++; $display("FAIL scrub_entry: ready=%b busy=%b ek=%h want 0 1 0", ready_o, busy_o, exp_key_o);
        end
        repeat (10) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL scrub_len_short: busy=%b want 1", busy_o); end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL scrub_len_long: busy=%b want 0", busy_o); end
        for (int i = 0; i < 11; i++) if (dut.u_regfile.mem_q[i] != '0) nz++;
        checks++;
        if (nz != 0) begin errors++; $display("FAIL scrub_store: nonzero entries=%0d want 0", nz); end
        pulse_load(FipsKey);
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL scrub_reload_timeout: ready=%b want 1", ready_o); end
        do_read(4'd7);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_key_o !== brev(fips_rk(7))) begin
            errors++; $display("FAIL scrub_reload_read: valid=%b got %h want %h", rd_valid_o, rd_key_o, brev(fips_rk(7)));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_read();
        test_back_to_back();
        test_load_ignored();
        test_bad_reads();
        test_reset_mid_build();
`ifdef AES128_RKS_SCRUB_EN
        test_scrub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
